// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM scheduler: FSM states, default command codes,
// config flag bit positions and the QUERY reply word layout.
package pwm_pkg;

  typedef enum logic [3:0] {
    IDLE, CFG_CYCLE, CFG_ON, CFG_FLAGS, CFG_DUR, SCH_TIME, SCH_ON, QUERY, REPLY
  } state_t;

  localparam int unsigned DEF_CMD_CONFIG_PWM   = 2;
  localparam int unsigned DEF_CMD_SCHEDULE_PWM = 3;
  localparam int unsigned DEF_CMD_QUERY_PWM    = 4;

  localparam int unsigned FLAG_DEFAULT = 0;
  localparam int unsigned FLAG_INVERT  = 1;

  localparam int unsigned QRY_OVF_BIT = 31;
  localparam int unsigned QRY_CNT_LSB = 24;
  localparam int unsigned QRY_CNT_W   = 7;
  localparam int unsigned QRY_ON_W    = 24;

  function automatic logic [31:0] query_word(input logic ovf,
                                             input logic [QRY_CNT_W-1:0] count,
                                             input logic [QRY_ON_W-1:0] on_ticks);
    logic [31:0] w;
    w = '0;
    w[QRY_OVF_BIT] = ovf;
    w[QRY_CNT_LSB +: QRY_CNT_W] = count;
    w[QRY_ON_W-1:0] = on_ticks;
    return w;
  endfunction

endpackage

// File: rtl/pwm_sched_fifo.sv
// Per-channel schedule queue; a push into a full queue is accepted when a pop
// frees a slot in the same cycle.
module pwm_sched_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 58
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pwm_sched.sv
// Multi-channel PWM generator with a time-scheduled duty queue per channel,
// driven by a word-serial command interface.
module pwm_sched import pwm_pkg::*; #(
  parameter int unsigned NPWM     = 12,
  parameter int unsigned PWM_BITS = 26,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned CMD_BITS = 8,
  parameter logic [CMD_BITS-1:0] CMD_CONFIG_PWM   = CMD_BITS'(DEF_CMD_CONFIG_PWM),
  parameter logic [CMD_BITS-1:0] CMD_SCHEDULE_PWM = CMD_BITS'(DEF_CMD_SCHEDULE_PWM),
  parameter logic [CMD_BITS-1:0] CMD_QUERY_PWM    = CMD_BITS'(DEF_CMD_QUERY_PWM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         systime,
  input  logic                shutdown,
  input  logic [31:0]         arg_data,
  output logic                arg_advance,
  input  logic [CMD_BITS-1:0] cmd,
  input  logic                cmd_ready,
  output logic                cmd_done,
  output logic [31:0]         param_data,
  output logic                param_write,
  output logic [NPWM-1:0]     pwm
);
  localparam int unsigned CH_W  = (NPWM > 1) ? $clog2(NPWM) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned QW    = 32 + PWM_BITS;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);

  state_t             state;
  logic [CH_W-1:0]    ch;
  logic [31:0]        sch_time;
  logic [31:0]        qword;

  logic [PWM_BITS-1:0] cycle_ticks [NPWM];
  logic [PWM_BITS-1:0] on_ticks    [NPWM];
  logic [PWM_BITS-1:0] max_dur     [NPWM];
  logic [PWM_BITS-1:0] dur         [NPWM];
  logic [PWM_BITS-1:0] cnt         [NPWM];
  logic [NPWM-1:0]     def_val, invert, ovf;

  logic [NPWM-1:0]     sel, q_push, q_pop, q_flush, q_full, q_empty;
  logic [QW-1:0]       q_din;
  logic [QW-1:0]       q_dout  [NPWM];
  logic [CNT_W-1:0]    q_count [NPWM];

  assign q_din = {sch_time, arg_data[PWM_BITS-1:0]};

  for (genvar g = 0; g < NPWM; g++) begin : g_queue
    pwm_sched_fifo #(.DEPTH(QDEPTH), .WIDTH(QW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (q_push[g]),
      .pop   (q_pop[g]),
      .flush (q_flush[g]),
      .din   (q_din),
      .dout  (q_dout[g]),
      .count (q_count[g]),
      .full  (q_full[g]),
      .empty (q_empty[g])
    );
  end

  // Head is due once systime has reached it, judged on the wrapped difference.
  always_comb begin
    sel = '0; q_push = '0; q_pop = '0; q_flush = '0;
    for (int unsigned i = 0; i < NPWM; i++) begin
      sel[i]     = (ch == CH_W'(i));
      q_pop[i]   = !shutdown && !q_empty[i] &&
                   ($signed(systime - q_dout[i][QW-1 -: 32]) >= 0);
      q_push[i]  = !shutdown && sel[i] && (state == SCH_ON);
      q_flush[i] = shutdown || (sel[i] && (state == CFG_DUR));
    end
  end

  always_comb begin
    qword = '0;
    for (int unsigned i = 0; i < NPWM; i++)
      if (sel[i])
        qword = query_word(ovf[i], QRY_CNT_W'(q_count[i]), QRY_ON_W'(on_ticks[i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      sch_time    <= '0;
      cmd_done    <= 1'b0;
      param_write <= 1'b0;
      param_data  <= '0;
      arg_advance <= 1'b0;
    end else begin
      cmd_done    <= 1'b0;
      param_write <= 1'b0;
      arg_advance <= 1'b1;
      case (state)
        IDLE: begin
          arg_advance <= 1'b0;
          if (cmd_ready) begin
            ch <= arg_data[CH_W-1:0];
            arg_advance <= 1'b1;
            if (cmd == CMD_CONFIG_PWM)        state <= CFG_CYCLE;
            else if (cmd == CMD_SCHEDULE_PWM) state <= SCH_TIME;
            else if (cmd == CMD_QUERY_PWM)    state <= QUERY;
            else begin
              cmd_done    <= 1'b1;
              arg_advance <= 1'b0;
            end
          end
        end
        CFG_CYCLE: state <= CFG_ON;
        CFG_ON:    state <= CFG_FLAGS;
        CFG_FLAGS: state <= CFG_DUR;
        SCH_TIME: begin
          sch_time <= arg_data;
          state    <= SCH_ON;
        end
        QUERY: begin
          param_data  <= qword;
          param_write <= 1'b1;
          state       <= REPLY;
        end
        CFG_DUR, SCH_ON, REPLY: begin
          cmd_done    <= 1'b1;
          arg_advance <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          arg_advance <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // on_ticks priority: shutdown > CONFIG write > schedule apply > expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm     <= '0;
      def_val <= '0;
      invert  <= '0;
      ovf     <= '0;
      for (int unsigned i = 0; i < NPWM; i++) begin
        cycle_ticks[i] <= '0;
        on_ticks[i]    <= '0;
        max_dur[i]     <= '0;
        dur[i]         <= '0;
        cnt[i]         <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NPWM; i++) begin
        if (sel[i] && state == CFG_CYCLE) cycle_ticks[i] <= arg_data[PWM_BITS-1:0];
        if (sel[i] && state == CFG_FLAGS) begin
          def_val[i] <= arg_data[FLAG_DEFAULT];
          invert[i]  <= arg_data[FLAG_INVERT];
        end
        if (sel[i] && state == CFG_DUR) max_dur[i] <= arg_data[PWM_BITS-1:0];

        if (sel[i] && state == CFG_DUR)                 ovf[i] <= 1'b0;
        else if (q_push[i] && q_full[i] && !q_pop[i])   ovf[i] <= 1'b1;

        if (shutdown)                        on_ticks[i] <= {PWM_BITS{def_val[i]}};
        else if (sel[i] && state == CFG_ON)  on_ticks[i] <= arg_data[PWM_BITS-1:0];
        else if (q_pop[i])                   on_ticks[i] <= q_dout[i][PWM_BITS-1:0];
        else if (dur[i] == ONE)              on_ticks[i] <= {PWM_BITS{def_val[i]}};

        if (q_pop[i])           dur[i] <= max_dur[i];
        else if (dur[i] != '0)  dur[i] <= dur[i] - ONE;

        if (cycle_ticks[i] <= ONE)                  cnt[i] <= '0;
        else if (cnt[i] >= cycle_ticks[i] - ONE)    cnt[i] <= '0;
        else                                        cnt[i] <= cnt[i] + ONE;

        pwm[i] <= ((cycle_ticks[i] <= ONE) ? (on_ticks[i] != '0)
                                           : (cnt[i] < on_ticks[i])) ^ invert[i];
      end
    end
  end

endmodule
